line_sequencer: RTL and testbench
=================================

# line_sequencer

Parametrised segment sequencer that drives a `line_drawer` with a programmable table of up to NUM_SEGS line segments and animates them by drawing, holding, and erasing. It replaces the fixed case-table and free-running counter in the top level. It sits between the on-board controls and `line_drawer`, whose `x`/`y` outputs feed `VGA_framebuffer`. It uses a start/done handshake, so every line completes before the next one begins.

## Interface
- NUM_SEGS, 8, number of table entries (≥2); IDX_W = $clog2(NUM_SEGS)
- COORD_W, 11, width of every coordinate
- HOLD_W, 24, width of the hold counter
- PASS_W, 8, width of the pass counter
---
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- enable  in  1  run request, level
- mode  in  1  0 = paired (draw i, hold, erase i), 1 = sweep (draw all, hold, erase all)
- hold_cycles  in  HOLD_W  hold duration in clk cycles; 0 = no hold
- tbl_we  in  1  table write strobe
- tbl_addr  in  IDX_W  table write index
- tbl_x0, tbl_y0, tbl_x1, tbl_y1  in  COORD_W each  segment write data
- ld_start  out  1  one-cycle start pulse to `line_drawer`
- ld_x0, ld_y0, ld_x1, ld_y1  out  COORD_W each  latched segment endpoints
- ld_color  out  1  1 = draw, 0 = erase; wired to framebuffer `pixel_write`
- ld_done  in  1  `line_drawer` completion level
- seg_idx  out  IDX_W  index of the current segment
- busy  out  1  high in every state except IDLE
- pass_count  out  PASS_W  count of completed full passes, wraps

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE → ISSUE when enable = 1. Mode is latched on this transition and again at every pass wrap.
- ISSUE (one cycle): table[seg_idx] is latched into ld_*, ld_color is set for the current phase, ld_start = 1. Next state is WAIT.
- WAIT: stays until ld_done = 1. `line_drawer` must deassert done within one cycle of start; ld_done is ignored in the ISSUE cycle.
- Step after WAIT, paired mode:
  - After a draw: go to HOLD.
  - After an erase: seg_idx+1, then go to ISSUE with a draw.
- Step after WAIT, sweep mode:
  - seg_idx+1 while seg_idx < NUM_SEGS−1, then go to ISSUE with the same phase.
  - At the last index after a draw: go to HOLD, then erase starting from 0.
- HOLD: waits hold_cycles cycles, then goes to ISSUE with an erase. hold_cycles = 0 skips the wait (HOLD lasts one cycle).
- Pass wrap: after the final erase of index NUM_SEGS−1, seg_idx → 0 and pass_count+1 (wraps modulo 2^PASS_W).
- enable is sampled only at pass-safe boundaries (after an erase completes). If it is 0 there, go to IDLE with seg_idx → 0. The screen is never left with a half-animated line.
- Table writes are accepted in any state and take effect at the next ISSUE that reads that entry. A line in flight keeps its latched coordinates.
- Arithmetic: seg_idx wraps at NUM_SEGS, not at 2^IDX_W. The hold counter loads hold_cycles−1 and counts down to 0.

## Timing
- Reset values:
  - state = IDLE; ld_start, ld_color, busy, seg_idx, pass_count = 0; ld_* coordinates = 0.
  - Table contents are not reset.
- Reset asserted mid-line: next-cycle outputs match the reset values. `line_drawer` shares the same reset.
- Latency enable→ld_start: 1 cycle (IDLE→ISSUE registers, ld_start high in the ISSUE cycle).
- ld_done→next ld_start: 1 cycle with no hold. At a HOLD step it is hold_cycles+1 cycles.
- Simultaneous tbl_we and ISSUE on the same entry: the old value is latched (read-before-write).

## Configuration
- LINE_SEQ_ERASE_EN defined: behaviour as above. ld_color alternates between draw and erase.
- LINE_SEQ_ERASE_EN undefined: the erase phase is removed and ld_color is tied to 1.
  - Paired mode: draw i, HOLD, i+1.
  - Sweep mode: draw all, HOLD, wrap.
  - The enable boundary becomes every HOLD exit.

## Structure
- Package `line_seq_pkg` holds:
  - `state_t` enum {IDLE, ISSUE, WAIT, HOLD};
  - `phase_t` {DRAW, ERASE};
  - default-width constants COORD_W_DEF = 11, HOLD_W_DEF = 24.
- One sub-module, `hold_timer`: load, count down, and a `expired` flag.
- The segment table is a register array inside `line_sequencer`.

## Test plan
- Reset, then enable=1: ld_start pulses exactly one cycle after enable, with ld_* = table[0] and ld_color=1.
- Paired mode, NUM_SEGS=4, hold_cycles=3, ld_done answered 5 cycles after each start:
  - order is D0, E0, D1, E1, …, E3;
  - exactly 3 cycles of HOLD before each erase;
  - pass_count = 1 after E3.
- Sweep mode: ld_start order is D0–D3, then E0–E3. seg_idx wraps 3→0 and hold occurs once per pass.
- enable dropped during D2 in paired mode: E2 still issues, then IDLE with busy=0 and seg_idx=0.
- tbl_we to entry 1 while entry 1 is in WAIT: the in-flight coordinates are unchanged, and the next D1 uses the new data.
- Reset asserted during WAIT, and again with LINE_SEQ_ERASE_EN undefined:
  - all outputs are 0 the following cycle;
  - with the macro undefined, ld_color is never 0.

Source files
------------

// File: rtl/line_seq_pkg.sv
// Shared types and default widths for the line sequencer slice.
package line_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    typedef enum logic {
        DRAW,
        ERASE
    } phase_t;

    localparam int COORD_W_DEF = 11;
    localparam int HOLD_W_DEF  = 24;

endpackage

// File: rtl/line_sequencer_hold_timer.sv
// hold_timer: loads a cycle count and counts down to zero; o_expired is
// high whenever the count is zero. A load of 0 behaves like a load of 1.
module hold_timer
    import line_seq_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [HOLD_W-1:0] i_cycles,
    output logic              o_expired
);

    logic [HOLD_W-1:0] r_count;

    // Count register: load cycles-1 on entry, then decrement to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_cycles == '0) ? '0 : i_cycles - 1'b1;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/line_sequencer.sv
// line_sequencer: walks a programmable segment table and feeds line_drawer
// with a start/done handshake, animating draw / hold / erase.
// Build option: define LINE_SEQ_ERASE_EN to enable the erase phase; when it
// is undefined lines are only drawn and ld_color is tied high.
module line_sequencer
    import line_seq_pkg::*;
#(
    parameter  int NUM_SEGS = 8,
    parameter  int COORD_W  = COORD_W_DEF,
    parameter  int HOLD_W   = HOLD_W_DEF,
    parameter  int PASS_W   = 8,
    localparam int IDX_W    = $clog2(NUM_SEGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               mode,
    input  logic [HOLD_W-1:0]  hold_cycles,
    input  logic               tbl_we,
    input  logic [IDX_W-1:0]   tbl_addr,
    input  logic [COORD_W-1:0] tbl_x0,
    input  logic [COORD_W-1:0] tbl_y0,
    input  logic [COORD_W-1:0] tbl_x1,
    input  logic [COORD_W-1:0] tbl_y1,
    output logic               ld_start,
    output logic [COORD_W-1:0] ld_x0,
    output logic [COORD_W-1:0] ld_y0,
    output logic [COORD_W-1:0] ld_x1,
    output logic [COORD_W-1:0] ld_y1,
    output logic               ld_color,
    input  logic               ld_done,
    output logic [IDX_W-1:0]   seg_idx,
    output logic               busy,
    output logic [PASS_W-1:0]  pass_count
);

    logic [4*COORD_W-1:0] r_table [NUM_SEGS];

    state_t               r_state, w_state_nx;
    logic [IDX_W-1:0]     r_idx, w_idx_nx, w_idx_inc;
    logic                 r_mode;
    logic [PASS_W-1:0]    r_pass;
    logic [COORD_W-1:0]   r_x0, r_y0, r_x1, r_y1;
    logic                 w_last, w_wrap, w_latch_mode;
    logic                 w_hold_load, w_expired;
`ifdef LINE_SEQ_ERASE_EN
    phase_t               r_phase, w_phase_nx;
    logic                 r_color;
`endif

    assign w_last      = (r_idx == IDX_W'(NUM_SEGS - 1));
    assign w_idx_inc   = w_last ? '0 : r_idx + 1'b1;
    assign w_hold_load = (w_state_nx == HOLD) && (r_state != HOLD);

    hold_timer #(
        .HOLD_W (HOLD_W)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_hold_load),
        .i_cycles  (hold_cycles),
        .o_expired (w_expired)
    );

    // Segment table: written at any time, never reset.
    always_ff @(posedge clk) begin
        if (tbl_we && (32'(tbl_addr) < NUM_SEGS)) begin
            r_table[tbl_addr] <= {tbl_x0, tbl_y0, tbl_x1, tbl_y1};
        end
    end

    // Next state, next index and pass-boundary decisions.
    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_wrap       = 1'b0;
        w_latch_mode = 1'b0;
`ifdef LINE_SEQ_ERASE_EN
        w_phase_nx   = r_phase;
`endif
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nx   = ISSUE;
                    w_idx_nx     = '0;
                    w_latch_mode = 1'b1;
`ifdef LINE_SEQ_ERASE_EN
                    w_phase_nx   = DRAW;
`endif
                end
            end
            ISSUE: begin
                w_state_nx = WAIT;
            end
            WAIT: begin
                if (ld_done) begin
`ifdef LINE_SEQ_ERASE_EN
                    if (r_phase == DRAW) begin
                        if (!r_mode || w_last) begin
                            w_state_nx = HOLD;
                        end else begin
                            w_state_nx = ISSUE;
                            w_idx_nx   = w_idx_inc;
                        end
                    end else begin
                        // An erase finished: mid-sweep keeps erasing, otherwise
                        // this is a safe point to start over or stop.
                        w_state_nx = ISSUE;
                        w_idx_nx   = w_idx_inc;
                        w_phase_nx = (r_mode && !w_last) ? ERASE : DRAW;
                        if (w_last) begin
                            w_wrap       = 1'b1;
                            w_latch_mode = 1'b1;
                        end
                        if ((!r_mode || w_last) && !enable) begin
                            w_state_nx = IDLE;
                            w_idx_nx   = '0;
                        end
                    end
`else
                    if (!r_mode || w_last) begin
                        w_state_nx = HOLD;
                    end else begin
                        w_state_nx = ISSUE;
                        w_idx_nx   = w_idx_inc;
                    end
`endif
                end
            end
            HOLD: begin
                if (w_expired) begin
`ifdef LINE_SEQ_ERASE_EN
                    w_state_nx = ISSUE;
                    w_phase_nx = ERASE;
                    if (r_mode) begin
                        w_idx_nx = '0;
                    end
`else
                    w_state_nx = ISSUE;
                    w_idx_nx   = w_idx_inc;
                    if (w_last) begin
                        w_wrap       = 1'b1;
                        w_latch_mode = 1'b1;
                    end
                    if (!enable) begin
                        w_state_nx = IDLE;
                        w_idx_nx   = '0;
                    end
`endif
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State, counters and the segment latch taken on entry to ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_mode  <= 1'b0;
            r_pass  <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
`ifdef LINE_SEQ_ERASE_EN
            r_phase <= DRAW;
            r_color <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            if (w_latch_mode) begin
                r_mode <= mode;
            end
            if (w_wrap) begin
                r_pass <= r_pass + 1'b1;
            end
            if (w_state_nx == ISSUE) begin
                {r_x0, r_y0, r_x1, r_y1} <= r_table[w_idx_nx];
            end
`ifdef LINE_SEQ_ERASE_EN
            r_phase <= w_phase_nx;
            if (w_state_nx == ISSUE) begin
                r_color <= (w_phase_nx == DRAW);
            end
`endif
        end
    end

    assign ld_start   = (r_state == ISSUE);
    assign ld_x0      = r_x0;
    assign ld_y0      = r_y0;
    assign ld_x1      = r_x1;
    assign ld_y1      = r_y1;
`ifdef LINE_SEQ_ERASE_EN
    assign ld_color   = r_color;
`else
    assign ld_color   = 1'b1;
`endif
    assign seg_idx    = r_idx;
    assign busy       = (r_state != IDLE);
    assign pass_count = r_pass;

endmodule

// File: tb/tb_line_sequencer.sv
// Scoreboard bench for line_sequencer (NUM_SEGS=4). Works with or without
// LINE_SEQ_ERASE_EN; the expected start order follows the build.
module tb_line_sequencer;

    localparam int N  = 4;
    localparam int CW = 11;
    localparam int HW = 24;
    localparam int PW = 8;
    localparam int IW = 2;
`ifdef LINE_SEQ_ERASE_EN
    localparam int   L         = 2 * N;
    localparam logic RST_COLOR = 1'b0;
`else
    localparam int   L         = N;
    localparam logic RST_COLOR = 1'b1;
`endif

    logic          clk, reset, enable, mode;
    logic [HW-1:0] hold_cycles;
    logic          tbl_we;
    logic [IW-1:0] tbl_addr;
    logic [CW-1:0] tbl_x0, tbl_y0, tbl_x1, tbl_y1;
    logic          ld_start, ld_color, ld_done;
    logic [CW-1:0] ld_x0, ld_y0, ld_x1, ld_y1;
    logic [IW-1:0] seg_idx;
    logic          busy;
    logic [PW-1:0] pass_count;

    line_sequencer #(
        .NUM_SEGS (N),
        .COORD_W  (CW),
        .HOLD_W   (HW),
        .PASS_W   (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .hold_cycles (hold_cycles),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_x0      (tbl_x0),
        .tbl_y0      (tbl_y0),
        .tbl_x1      (tbl_x1),
        .tbl_y1      (tbl_y1),
        .ld_start    (ld_start),
        .ld_x0       (ld_x0),
        .ld_y0       (ld_y0),
        .ld_x1       (ld_x1),
        .ld_y1       (ld_y1),
        .ld_color    (ld_color),
        .ld_done     (ld_done),
        .seg_idx     (seg_idx),
        .busy        (busy),
        .pass_count  (pass_count)
    );

    typedef struct {
        logic [IW-1:0]   idx;
        logic            color;
        logic [4*CW-1:0] coords;
        int              gap;
    } exp_t;

    exp_t            exp_q[$];
    logic [4*CW-1:0] tb_tbl [N];
    int              tests = 0;
    int              fails = 0;
    int              n_starts = 0;
    int              cyc = 0;
    int              last_start = 0;
    logic            color_zero_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // line_drawer stand-in: done drops at start and rises 5 cycles later.
    initial begin
        int cnt;
        cnt = 0;
        ld_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ld_done = 1'b0;
                cnt = 0;
            end else if (ld_start) begin
                ld_done = 1'b0;
                cnt = 5;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) ld_done = 1'b1;
            end
        end
    end

    // Monitor: every start pulse pops and checks one expected segment.
    initial begin
        exp_t            e;
        logic [4*CW-1:0] act;
        forever begin
            @(negedge clk);
            if (!reset && ld_start) begin
                n_starts++;
                act = {ld_x0, ld_y0, ld_x1, ld_y1};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_start: got idx %0d color %0b, expected no start", seg_idx, ld_color);
                end else begin
                    e = exp_q.pop_front();
                    check("start_idx", 64'(seg_idx), 64'(e.idx));
                    check("start_color", 64'(ld_color), 64'(e.color));
                    check("start_coords", 64'(act), 64'(e.coords));
                    if (e.gap != 0) check("start_gap", 64'(cyc - last_start), 64'(e.gap));
                end
                last_start = cyc;
            end
`ifndef LINE_SEQ_ERASE_EN
            if (ld_color !== 1'b1) color_zero_seen = 1'b1;
`endif
        end
    end

    // Queue the expected start sequence: positions within one pass, with
    // the start-to-start spacing (5-cycle drawer + hold where one occurs).
    task automatic push_seq(input bit sweep, input int first, input int count,
                            input int hcyc, input bit first_unchecked);
        int   h, p;
        exp_t e;
        h = (hcyc < 1) ? 1 : hcyc;
        for (int k = 0; k < count; k++) begin
            p = (first + k) % L;
`ifdef LINE_SEQ_ERASE_EN
            if (sweep) begin
                e.idx   = IW'(p % N);
                e.color = (p < N);
                e.gap   = (p == N) ? 6 + h : 6;
            end else begin
                e.idx   = IW'(p / 2);
                e.color = ((p % 2) == 0);
                e.gap   = ((p % 2) == 1) ? 6 + h : 6;
            end
`else
            e.idx   = IW'(p);
            e.color = 1'b1;
            e.gap   = sweep ? ((p == 0) ? 6 + h : 6) : 6 + h;
`endif
            e.coords = tb_tbl[e.idx];
            if (k == 0 && first_unchecked) e.gap = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic write_tbl(input int idx, input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                             input logic [CW-1:0] x1, input logic [CW-1:0] y1);
        tbl_we   = 1'b1;
        tbl_addr = IW'(idx);
        tbl_x0   = x0;
        tbl_y0   = y0;
        tbl_x1   = x1;
        tbl_y1   = y1;
        @(negedge clk);
        #1;
        tbl_we = 1'b0;
        tb_tbl[idx] = {x0, y0, x1, y1};
    endtask

    task automatic wait_starts(input int target, input string name);
        for (int i = 0; i < 3000 && n_starts < target; i++) begin
            @(negedge clk);
            #1;
        end
        check({"reach_", name}, 64'(n_starts >= target), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && busy !== 1'b0; i++) begin
            @(negedge clk);
            #1;
        end
        check({"idle_", name}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_start"}, 64'(ld_start), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_seg_idx"}, 64'(seg_idx), 64'd0);
        check({tag, "_pass"}, 64'(pass_count), 64'd0);
        check({tag, "_coords"}, 64'({ld_x0, ld_y0, ld_x1, ld_y1}), 64'd0);
        check({tag, "_color"}, 64'(ld_color), 64'(RST_COLOR));
    endtask

    initial begin
        int              base, pre, post, drop_at, total;
        logic [4*CW-1:0] old1;

        reset       = 1'b1;
        enable      = 1'b0;
        mode        = 1'b0;
        hold_cycles = '0;
        tbl_we      = 1'b0;
        tbl_addr    = '0;
        tbl_x0      = '0;
        tbl_y0      = '0;
        tbl_x1      = '0;
        tbl_y1      = '0;
        @(negedge clk);
        #1;
        for (int k = 0; k < N; k++)
            write_tbl(k, CW'(100 + k), CW'(200 + k), CW'(300 + k), CW'(400 + k));
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        #1;

        // Paired pass, hold 3; first start one cycle after enable.
        mode = 1'b0;
        hold_cycles = HW'(3);
        push_seq(1'b0, 0, L, 3, 1'b1);
        base = n_starts;
        enable = 1'b1;
        @(negedge clk);
        check("first_start", 64'(ld_start), 64'd1);
        check("first_coords", 64'({ld_x0, ld_y0, ld_x1, ld_y1}), 64'(tb_tbl[0]));
        check("first_color", 64'(ld_color), 64'd1);
        #1;
        wait_starts(base + L, "paired");
        enable = 1'b0;
        wait_idle("paired");
        check("paired_pass", 64'(pass_count), 64'd1);
        check("paired_seg_idx", 64'(seg_idx), 64'd0);

        // Sweep pass, hold 3.
        mode = 1'b1;
        push_seq(1'b1, 0, L, 3, 1'b1);
        base = n_starts;
        enable = 1'b1;
        wait_starts(base + L, "sweep");
        enable = 1'b0;
        wait_idle("sweep");
        check("sweep_pass", 64'(pass_count), 64'd2);
        check("sweep_seg_idx", 64'(seg_idx), 64'd0);

        // Enable dropped while segment 2 is being drawn (paired, hold 2).
        mode = 1'b0;
        hold_cycles = HW'(2);
`ifdef LINE_SEQ_ERASE_EN
        drop_at = 5;
        total   = 6;
`else
        drop_at = 3;
        total   = 3;
`endif
        push_seq(1'b0, 0, total, 2, 1'b1);
        base = n_starts;
        enable = 1'b1;
        wait_starts(base + drop_at, "drop");
        enable = 1'b0;
        wait_idle("drop");
        check("drop_starts", 64'(n_starts - base), 64'(total));
        check("drop_seg_idx", 64'(seg_idx), 64'd0);
        check("drop_pass", 64'(pass_count), 64'd2);

        // Rewrite entry 1 while it is in flight (paired, hold 0).
        hold_cycles = '0;
`ifdef LINE_SEQ_ERASE_EN
        pre  = 3;
        post = 9;
        drop_at = 11;
        total   = 12;
`else
        pre  = 2;
        post = 4;
        drop_at = 6;
        total   = 6;
`endif
        push_seq(1'b0, 0, pre, 0, 1'b1);
        base = n_starts;
        enable = 1'b1;
        wait_starts(base + pre, "tblw");
        @(negedge clk);
        #1;
        old1 = tb_tbl[1];
        write_tbl(1, CW'(11'h7AB), CW'(11'h055), CW'(11'h3C3), CW'(11'h0F0));
        check("inflight_coords", 64'({ld_x0, ld_y0, ld_x1, ld_y1}), 64'(old1));
        check("inflight_seg_idx", 64'(seg_idx), 64'd1);
        push_seq(1'b0, pre, post, 0, 1'b0);
        wait_starts(base + drop_at, "tblw_new");
        enable = 1'b0;
        wait_idle("tblw");
        check("tblw_starts", 64'(n_starts - base), 64'(total));
        check("tblw_pass", 64'(pass_count), 64'd3);

        // Reset asserted during WAIT.
        mode = 1'b0;
        hold_cycles = HW'(3);
        push_seq(1'b0, 0, 1, 3, 1'b1);
        base = n_starts;
        enable = 1'b1;
        wait_starts(base + 1, "rst");
        @(negedge clk);
        #1;
        enable = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("post_reset_idle", 64'(busy), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifndef LINE_SEQ_ERASE_EN
        check("color_never_zero", 64'(color_zero_seen), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
